// File: rtl/nand_counter.sv
// rtl/nand_counter.sv - loadable up-counter built from NAND cells, with a registered wrap pulse
// All next-state logic is NAND instances; the only behavioural blocks are the state flops.

module basic_nand (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = ~(a & b);
endmodule

// Relay model: two series contacts pull the output low only when both coils are energised.
module physical_level_nand (
  input  logic a,
  input  logic b,
  output logic y
);
  logic pull_down;
  assign pull_down = a & b;
  assign y = pull_down ? 1'b0 : 1'b1;
endmodule

module nand_cell #(
  parameter bit USE_PHYSICAL = 1'b0
) (
  input  logic a,
  input  logic b,
  output logic y
);
  generate
    if (USE_PHYSICAL) begin : g_phys
      physical_level_nand u_nand (.a(a), .b(b), .y(y));
    end else begin : g_basic
      basic_nand u_nand (.a(a), .b(b), .y(y));
    end
  endgenerate
endmodule

module nand_counter #(
  parameter int WIDTH        = 16,
  parameter bit USE_PHYSICAL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             st,
  input  logic             en,
  input  logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] q,
  output logic             wrap
);
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] d;
  logic             wrap_nst;
  logic             wrap_n;
  logic             wrap_d;

  assign carry[0] = en;

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      logic xor_t, xor_u, xor_v;
      logic and_n;
      logic nst, mux_a, mux_b;

      // Half adder: sum = q ^ c (4 NANDs), carry = q & c (2 NANDs)
      nand_cell #(.USE_PHYSICAL(USE_PHYSICAL)) u_xor0 (.a(q[i]),  .b(carry[i]), .y(xor_t));
      nand_cell #(.USE_PHYSICAL(USE_PHYSICAL)) u_xor1 (.a(q[i]),  .b(xor_t),    .y(xor_u));
      nand_cell #(.USE_PHYSICAL(USE_PHYSICAL)) u_xor2 (.a(carry[i]), .b(xor_t), .y(xor_v));
      nand_cell #(.USE_PHYSICAL(USE_PHYSICAL)) u_xor3 (.a(xor_u), .b(xor_v),    .y(sum[i]));
      nand_cell #(.USE_PHYSICAL(USE_PHYSICAL)) u_and0 (.a(q[i]),  .b(carry[i]), .y(and_n));
      nand_cell #(.USE_PHYSICAL(USE_PHYSICAL)) u_and1 (.a(and_n), .b(and_n),    .y(carry[i+1]));

      // Gating x with st keeps an unknown x out of q while not loading.
      nand_cell #(.USE_PHYSICAL(USE_PHYSICAL)) u_mux0 (.a(st),     .b(st),     .y(nst));
      nand_cell #(.USE_PHYSICAL(USE_PHYSICAL)) u_mux1 (.a(x[i]),   .b(st),     .y(mux_a));
      nand_cell #(.USE_PHYSICAL(USE_PHYSICAL)) u_mux2 (.a(sum[i]), .b(nst),    .y(mux_b));
      nand_cell #(.USE_PHYSICAL(USE_PHYSICAL)) u_mux3 (.a(mux_a),  .b(mux_b),  .y(d[i]));
    end
  endgenerate

  // Final carry only rises when en=1 and q is all-ones; a load suppresses it.
  nand_cell #(.USE_PHYSICAL(USE_PHYSICAL)) u_wrap0 (.a(st),           .b(st),       .y(wrap_nst));
  nand_cell #(.USE_PHYSICAL(USE_PHYSICAL)) u_wrap1 (.a(carry[WIDTH]), .b(wrap_nst), .y(wrap_n));
  nand_cell #(.USE_PHYSICAL(USE_PHYSICAL)) u_wrap2 (.a(wrap_n),       .b(wrap_n),   .y(wrap_d));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q    <= '0;
      wrap <= 1'b0;
    end else begin
      q    <= d;
      wrap <= wrap_d;
    end
  end
endmodule

// File: tb/tb_nand_counter.sv
// tb/tb_nand_counter.sv - directed and equivalence checks for nand_counter

module tb_nand_counter;
  logic        clk = 1'b0;
  logic        rst;
  logic        st, en;
  logic [15:0] x;
  logic [15:0] q;
  logic        wrap;

  logic        sst, sen;
  logic [3:0]  sx;
  logic [3:0]  q_basic, q_phys;
  logic        wrap_basic, wrap_phys;

  int checks = 0;
  int errors = 0;

  logic [3:0] m_q;
  logic       m_w;

  always #5 clk = ~clk;

  nand_counter #(.WIDTH(16), .USE_PHYSICAL(1'b0)) u_dut (
    .clk(clk), .rst(rst), .st(st), .en(en), .x(x), .q(q), .wrap(wrap)
  );

  nand_counter #(.WIDTH(4), .USE_PHYSICAL(1'b0)) u_small_basic (
    .clk(clk), .rst(rst), .st(sst), .en(sen), .x(sx), .q(q_basic), .wrap(wrap_basic)
  );

  nand_counter #(.WIDTH(4), .USE_PHYSICAL(1'b1)) u_small_phys (
    .clk(clk), .rst(rst), .st(sst), .en(sen), .x(sx), .q(q_phys), .wrap(wrap_phys)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic small_step();
    if (sst) begin
      m_q = sx;
      m_w = 1'b0;
    end else if (sen) begin
      m_w = (m_q == 4'hF);
      m_q = m_q + 4'd1;
    end else begin
      m_w = 1'b0;
    end
    step();
  endtask

  initial begin
    rst = 1'b1; st = 1'b0; en = 1'b0; x = '0;
    sst = 1'b0; sen = 1'b0; sx = '0;
    m_q = '0; m_w = 1'b0;
    step(); step();
    check("reset_q", {16'h0, q}, 32'h0);
    check("reset_wrap", {31'h0, wrap}, 32'h0);
    rst = 1'b0;

    // Async reset between edges, and edges ignored while held
    st = 1'b1; x = 16'h1234;
    step();
    check("pre_reset_q", {16'h0, q}, 32'h1234);
    st = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("async_reset_q", {16'h0, q}, 32'h0);
    check("async_reset_wrap", {31'h0, wrap}, 32'h0);
    st = 1'b1; en = 1'b1; x = 16'hFFFF;
    step(); step();
    check("reset_hold_q", {16'h0, q}, 32'h0);
    rst = 1'b0; st = 1'b0; en = 1'b0;

    // Load, and load priority over enable
    st = 1'b1; x = 16'hBEEF;
    step();
    check("load_q", {16'h0, q}, 32'hBEEF);
    check("load_wrap", {31'h0, wrap}, 32'h0);
    en = 1'b1; x = 16'h0005;
    step();
    check("load_over_en_q", {16'h0, q}, 32'h0005);

    // Count and hold, with unknown x while not loading
    x = 16'h0000;
    step();
    st = 1'b0; en = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      check($sformatf("count_%0d", i), {16'h0, q}, i);
    end
    en = 1'b0; x = 'x;
    for (int i = 0; i < 3; i++) begin
      step();
      check("hold_q", {16'h0, q}, 32'd10);
      check("hold_wrap", {31'h0, wrap}, 32'h0);
    end

    // Wrap pulse
    st = 1'b1; x = 16'hFFFE;
    step();
    st = 1'b0; en = 1'b1;
    step();
    check("wrap_seq0_q", {16'h0, q}, 32'hFFFF);
    check("wrap_seq0_w", {31'h0, wrap}, 32'h0);
    step();
    check("wrap_seq1_q", {16'h0, q}, 32'h0000);
    check("wrap_seq1_w", {31'h0, wrap}, 32'h1);
    step();
    check("wrap_seq2_q", {16'h0, q}, 32'h0001);
    check("wrap_seq2_w", {31'h0, wrap}, 32'h0);
    st = 1'b1; x = 16'hFFFF;
    step();
    step();
    check("load_at_ones_q", {16'h0, q}, 32'hFFFF);
    check("load_at_ones_w", {31'h0, wrap}, 32'h0);

    // Reset mid-count
    x = 16'h0000;
    step();
    st = 1'b0; en = 1'b1;
    for (int i = 0; i < 7; i++) step();
    check("midcount_q", {16'h0, q}, 32'd7);
    rst = 1'b1;
    #1;
    check("midcount_rst_q", {16'h0, q}, 32'h0);
    step(); step();
    check("midcount_rst_hold_q", {16'h0, q}, 32'h0);
    rst = 1'b0;
    step();
    check("after_release_q", {16'h0, q}, 32'd1);
    en = 1'b0;

    // Primitive equivalence at WIDTH=4 against each other and a golden model
    m_q = q_basic; m_w = 1'b0;
    check("small_start_q", {28'h0, q_basic}, 32'h0);
    for (int i = 0; i < 200; i++) begin
      sst = ($urandom_range(0, 3) == 0);
      sen = $urandom_range(0, 1);
      sx  = 4'($urandom_range(0, 15));
      small_step();
      check("equiv_q", {28'h0, q_phys}, {28'h0, q_basic});
      check("equiv_wrap", {31'h0, wrap_phys}, {31'h0, wrap_basic});
      check("model_q", {28'h0, q_basic}, {28'h0, m_q});
      check("model_wrap", {31'h0, wrap_basic}, {31'h0, m_w});
    end
    for (int v = 0; v < 16; v++) begin
      sst = 1'b1; sen = 1'b0; sx = 4'(v);
      small_step();
      check("exh_load_basic", {28'h0, q_basic}, v);
      check("exh_load_phys", {28'h0, q_phys}, v);
      sst = 1'b0; sen = 1'b1;
      small_step();
      check("exh_inc_basic", {28'h0, q_basic}, (v + 1) % 16);
      check("exh_inc_phys", {28'h0, q_phys}, (v + 1) % 16);
      check("exh_wrap_basic", {31'h0, wrap_basic}, (v == 15) ? 32'h1 : 32'h0);
      check("exh_wrap_phys", {31'h0, wrap_phys}, (v == 15) ? 32'h1 : 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
